cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single clock, rising-edge active.
REQ-002 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port reqValid, input, 3, per-unit broadcast request; index 0 addsub ALU, 1 multiply ALU, 2 divide ALU (same index as ALUSel).
REQ-004 SHALL have ports reqTag0/reqTag1/reqTag2, input, 4 each, reservation-station tag of the producing entry.
REQ-005 SHALL have ports reqData0/reqData1/reqData2, input, 32 each, result value.
REQ-006 SHALL have port grant, output, 3, combinational one-hot accept; all-zero when nothing is accepted.
REQ-007 SHALL have port cdbValid, output, 1, registered CDB broadcast strobe.
REQ-008 SHALL have port cdbTag, output, 4, registered broadcast tag.
REQ-009 SHALL have port cdbData, output, 32, registered broadcast value.

Function
REQ-010 SHALL treat requester i as eligible only when reqValid[i]=1 and its tag is non-zero; tag 0 means "no producer" and is never granted or broadcast.
REQ-011 SHALL assert at most one grant bit per cycle.
REQ-012 SHALL assert grant only in a cycle where at least one requester is eligible.
REQ-013 SHALL hold a 2-bit round-robin pointer rrPtr, range 0..2; value 3 is unreachable.
REQ-014 SHALL search eligible requesters starting at rrPtr in the order rrPtr, rrPtr+1, rrPtr+2 (mod 3), and grant the first one found.
REQ-015 SHALL, on a clock edge with grant[i]=1, set rrPtr to (i+1) mod 3; with no grant, rrPtr SHALL hold.
REQ-016 Handshake: a requester SHALL hold reqValid, tag and data stable until the cycle in which its grant bit is 1. The transfer completes at that clock edge. The requester may present a new result in the very next cycle.
REQ-017 SHALL, on a clock edge with grant[i]=1, load cdbValid=1, cdbTag=reqTag_i and cdbData=reqData_i. Latency from grant to broadcast is exactly 1 cycle.
REQ-018 SHALL, on a clock edge with no grant, load cdbValid=0 and hold cdbTag and cdbData.
REQ-019 SHALL broadcast each granted result exactly once, for one cycle.
REQ-020 SHALL support back-to-back broadcasts every cycle while any requester is eligible.
REQ-021 SHALL treat a requester dropping reqValid before being granted as a withdrawal: no broadcast and no pointer change for it.
REQ-022 SHALL ignore reqTag and reqData of non-eligible requesters, including X values.

Reset
REQ-023 SHALL, while rst=1, force rrPtr=0, cdbValid=0, cdbTag=0 and cdbData=0 immediately, independent of clk.
REQ-024 SHALL drive grant=000 while rst=1.
REQ-025 SHALL drop any result granted in the same cycle that rst asserts.
REQ-026 SHALL resume arbitration with rrPtr=0 at the first rising clk edge after rst deasserts.

Configuration
REQ-027 SHALL, when CDB_FIXED_PRIO_EN is defined, use fixed priority divide(2) > multiply(1) > addsub(0). In this mode rrPtr SHALL remain 0 and is not updated.
REQ-028 SHALL, when CDB_FIXED_PRIO_EN is undefined, use the round-robin behaviour of REQ-013..REQ-015.
REQ-029 All other behaviour SHALL be identical in both configurations.

Verification
REQ-030 Single request: reset, then reqValid=001, reqTag0=4'h3, reqData0=32'h0000_0011. Required: grant=001 in the same cycle; next cycle cdbValid=1, cdbTag=3, cdbData=32'h11; the cycle after, cdbValid=0.
REQ-031 Round-robin rotation: reqValid=111 held for 6 cycles with tags 1/5/9. Required: grant sequence 001, 010, 100, 001, 010, 100, and broadcast tags 1, 5, 9, 1, 5, 9.
REQ-032 Zero tag: reqValid=010 with reqTag1=0. Required: grant=000, cdbValid stays 0, rrPtr unchanged.
REQ-033 Reset mid-operation: reqValid=111; assert rst asynchronously between edges after two grants. Required: cdbValid=0 immediately; after release, the first grant is 001.
REQ-034 Fixed priority (CDB_FIXED_PRIO_EN defined): reqValid=111 held for 3 cycles. Required: grant=100 on every cycle.
REQ-035 Withdrawal: reqValid=110 with rrPtr=1, then in the next cycle reqValid drops to 100 before bit 1 is granted again. Required: grant bit 1 never asserts for the withdrawn request, and no broadcast of its tag occurs.

Source files
------------

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter for three ALU result producers, registered broadcast.
// Define CDB_FIXED_PRIO_EN for fixed priority divide > multiply > addsub instead of round-robin.
module cdb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  reqValid,
   input  logic [3:0]  reqTag0,
   input  logic [3:0]  reqTag1,
   input  logic [3:0]  reqTag2,
   input  logic [31:0] reqData0,
   input  logic [31:0] reqData1,
   input  logic [31:0] reqData2,
   output logic [2:0]  grant,
   output logic        cdbValid,
   output logic [3:0]  cdbTag,
   output logic [31:0] cdbData
);

   logic [1:0]  rr_ptr;
   logic [1:0]  next_ptr;
   logic [2:0]  eligible;
   logic [3:0]  sel_tag;
   logic [31:0] sel_data;

   // Tag 0 means "no producer", so a zero-tag request is never eligible.
   always_comb begin
      eligible[0] = reqValid[0] && (reqTag0 != 4'd0);
      eligible[1] = reqValid[1] && (reqTag1 != 4'd0);
      eligible[2] = reqValid[2] && (reqTag2 != 4'd0);
   end

   always_comb begin
      grant = 3'b000;
      if (!rst) begin
`ifdef CDB_FIXED_PRIO_EN
         if (eligible[2])      grant = 3'b100;
         else if (eligible[1]) grant = 3'b010;
         else if (eligible[0]) grant = 3'b001;
`else
         case (rr_ptr)
            2'd1: begin
               if (eligible[1])      grant = 3'b010;
               else if (eligible[2]) grant = 3'b100;
               else if (eligible[0]) grant = 3'b001;
            end
            2'd2: begin
               if (eligible[2])      grant = 3'b100;
               else if (eligible[0]) grant = 3'b001;
               else if (eligible[1]) grant = 3'b010;
            end
            default: begin
               if (eligible[0])      grant = 3'b001;
               else if (eligible[1]) grant = 3'b010;
               else if (eligible[2]) grant = 3'b100;
            end
         endcase
`endif
      end
   end

   always_comb begin
      sel_tag  = reqTag0;
      sel_data = reqData0;
      if (grant[1]) begin
         sel_tag  = reqTag1;
         sel_data = reqData1;
      end else if (grant[2]) begin
         sel_tag  = reqTag2;
         sel_data = reqData2;
      end
   end

   // Pointer moves just past the winner; value 3 is never produced.
   always_comb begin
      next_ptr = rr_ptr;
`ifndef CDB_FIXED_PRIO_EN
      if (grant[0])      next_ptr = 2'd1;
      else if (grant[1]) next_ptr = 2'd2;
      else if (grant[2]) next_ptr = 2'd0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= 2'd0;
         cdbValid <= 1'b0;
         cdbTag   <= 4'd0;
         cdbData  <= 32'd0;
      end else begin
         rr_ptr   <= next_ptr;
         cdbValid <= |grant;
         if (|grant) begin
            cdbTag  <= sel_tag;
            cdbData <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter with a queue-free behavioural model.
// Honours CDB_FIXED_PRIO_EN the same way as the design.
module tb_cdb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  reqValid = 3'b000;
   logic [3:0]  reqTag0 = 4'd0, reqTag1 = 4'd0, reqTag2 = 4'd0;
   logic [31:0] reqData0 = 32'd0, reqData1 = 32'd0, reqData2 = 32'd0;
   logic [2:0]  grant;
   logic        cdbValid;
   logic [3:0]  cdbTag;
   logic [31:0] cdbData;

   int checks = 0;
   int errors = 0;
   logic seen_tag7 = 1'b0;

   int          m_ptr;
   logic        m_valid;
   logic [3:0]  m_tag;
   logic [31:0] m_data;

   logic [2:0] rot_grant [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   logic [3:0] rot_tag   [6] = '{4'd1, 4'd5, 4'd9, 4'd1, 4'd5, 4'd9};

   cdb_arbiter dut (
      .clk(clk), .rst(rst), .reqValid(reqValid),
      .reqTag0(reqTag0), .reqTag1(reqTag1), .reqTag2(reqTag2),
      .reqData0(reqData0), .reqData1(reqData1), .reqData2(reqData2),
      .grant(grant), .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Winner index from the arbitration rules, or -1 when nobody is eligible.
   function automatic int model_winner(input logic [2:0] v, input logic [3:0] t0, input logic [3:0] t1,
                                       input logic [3:0] t2, input int ptr);
      bit ok [3];
      ok[0] = (v[0] === 1'b1) && (t0 !== 4'd0);
      ok[1] = (v[1] === 1'b1) && (t1 !== 4'd0);
      ok[2] = (v[2] === 1'b1) && (t2 !== 4'd0);
`ifdef CDB_FIXED_PRIO_EN
      for (int i = 2; i >= 0; i--) if (ok[i]) return i;
`else
      for (int k = 0; k < 3; k++) if (ok[(ptr + k) % 3]) return (ptr + k) % 3;
`endif
      return -1;
   endfunction

   function automatic logic [2:0] onehot(input int w);
      logic [2:0] r;
      r = 3'b000;
      if (w >= 0) r[w] = 1'b1;
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ptr   <= 0;
         m_valid <= 1'b0;
         m_tag   <= 4'd0;
         m_data  <= 32'd0;
      end else begin
         int w;
         w = model_winner(reqValid, reqTag0, reqTag1, reqTag2, m_ptr);
         m_valid <= (w >= 0);
         if (w >= 0) begin
            m_tag  <= (w == 0) ? reqTag0 : (w == 1) ? reqTag1 : reqTag2;
            m_data <= (w == 0) ? reqData0 : (w == 1) ? reqData1 : reqData2;
`ifndef CDB_FIXED_PRIO_EN
            m_ptr  <= (w + 1) % 3;
`endif
         end
      end
   end

   always @(negedge clk) begin
      logic [2:0] eg;
      eg = rst ? 3'b000 : onehot(model_winner(reqValid, reqTag0, reqTag1, reqTag2, m_ptr));
      chk("model_grant", {29'd0, grant}, {29'd0, eg});
      chk("model_cdbValid", {31'd0, cdbValid}, {31'd0, m_valid});
      chk("model_cdbTag", {28'd0, cdbTag}, {28'd0, m_tag});
      chk("model_cdbData", cdbData, m_data);
      if (cdbValid && cdbTag == 4'd7) seen_tag7 <= 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      reqValid = 3'b000;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      // Reset state and single request; non-eligible requesters carry X.
      apply_reset();
      chk("reset_cdbValid", {31'd0, cdbValid}, 32'd0);
      chk("reset_cdbTag", {28'd0, cdbTag}, 32'd0);
      reqValid = 3'b001; reqTag0 = 4'h3; reqData0 = 32'h0000_0011;
      reqTag1 = 4'bxxxx; reqData2 = 32'hxxxx_xxxx;
      @(negedge clk); chk("single_grant", {29'd0, grant}, 32'h1);
      tick(); reqValid = 3'b000;
      @(negedge clk);
      chk("single_cdbValid", {31'd0, cdbValid}, 32'd1);
      chk("single_cdbTag", {28'd0, cdbTag}, 32'h3);
      chk("single_cdbData", cdbData, 32'h11);
      tick();
      @(negedge clk); chk("single_cdbValid_drop", {31'd0, cdbValid}, 32'd0);
      chk("single_tag_hold", {28'd0, cdbTag}, 32'h3);

      // Six cycles of all-valid requests.
      apply_reset();
      reqValid = 3'b111;
      reqTag0 = 4'd1; reqTag1 = 4'd5; reqTag2 = 4'd9;
      reqData0 = 32'd100; reqData1 = 32'd500; reqData2 = 32'd900;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
`ifdef CDB_FIXED_PRIO_EN
         if (i < 3) chk("fixed_grant", {29'd0, grant}, 32'h4);
`else
         chk("rot_grant", {29'd0, grant}, {29'd0, rot_grant[i]});
         if (i > 0) chk("rot_tag", {28'd0, cdbTag}, {28'd0, rot_tag[i-1]});
`endif
         tick();
      end
      reqValid = 3'b000;
      @(negedge clk);
      chk("b2b_cdbValid", {31'd0, cdbValid}, 32'd1);
`ifndef CDB_FIXED_PRIO_EN
      chk("rot_last_tag", {28'd0, cdbTag}, 32'd9);
`endif
      tick();

      // Zero tag is never granted, and the pointer stays where it was.
      reqValid = 3'b010; reqTag1 = 4'd0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("zero_grant", {29'd0, grant}, 32'd0);
         chk("zero_cdbValid", {31'd0, cdbValid}, 32'd0);
         tick();
      end
      reqValid = 3'b111; reqTag1 = 4'd5;
      @(negedge clk);
`ifdef CDB_FIXED_PRIO_EN
      chk("zero_ptr_hold", {29'd0, grant}, 32'h4);
`else
      chk("zero_ptr_hold", {29'd0, grant}, 32'h1);
`endif
      tick(); reqValid = 3'b000; tick();

      // Asynchronous reset after two grants.
      apply_reset();
      reqValid = 3'b111;
      tick(); tick();
      chk("pre_rst_cdbValid", {31'd0, cdbValid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_cdbValid", {31'd0, cdbValid}, 32'd0);
      chk("async_rst_cdbTag", {28'd0, cdbTag}, 32'd0);
      chk("async_rst_grant", {29'd0, grant}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
`ifdef CDB_FIXED_PRIO_EN
      chk("post_rst_grant", {29'd0, grant}, 32'h4);
`else
      chk("post_rst_grant", {29'd0, grant}, 32'h1);
`endif
      tick(); reqValid = 3'b000; tick();

      // Withdrawal: requester 1 posts tag 7, then drops it before being granted.
      apply_reset();
      reqValid = 3'b001; reqTag0 = 4'd2;
      tick();
      reqValid = 3'b110; reqTag1 = 4'd5; reqTag2 = 4'd9;
      @(negedge clk);
`ifndef CDB_FIXED_PRIO_EN
      chk("wd_grant1", {29'd0, grant}, 32'h2);
`endif
      tick(); reqTag1 = 4'd7;
      @(negedge clk); chk("wd_grant2", {29'd0, grant}, 32'h4);
      tick(); reqValid = 3'b100; reqTag2 = 4'd10;
      @(negedge clk); chk("wd_grant3", {29'd0, grant}, 32'h4);
      tick(); reqValid = 3'b000;
      tick(); tick();
      chk("wd_no_tag7", {31'd0, seen_tag7}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
